// File: rtl/sram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sram_bus_arbiter
//
// Shares one single-port memory bus between the core's instruction-fetch and
// data SRAM-like ports. Requests are serialised with data before instruction.
// Only one bus transaction is outstanding at a time. Read data is kept in one
// buffer per source. stall_by_sram holds the pipeline until every access the
// core enabled in the current cycle has completed.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   inst_sram_en/addr   fetch request and address
//   inst_sram_rdata     buffered fetch data
//   data_sram_en/wen/   data request, byte write enables (0 = read),
//     addr/wdata        address and store data
//   data_sram_rdata     buffered load data
//   stall_by_sram       pipeline stall to the core
//   mem_req/wr/wstrb/   bus request fields, held stable until mem_addr_ok
//     addr/wdata
//   mem_addr_ok         bus accepted the request this cycle
//   mem_data_ok         read data valid / write done this cycle
//   mem_rdata           bus read data
// -----------------------------------------------------------------------------
module sram_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // instruction port
  input  logic                inst_sram_en,
  input  logic [ADDR_W-1:0]   inst_sram_addr,
  output logic [DATA_W-1:0]   inst_sram_rdata,
  // data port
  input  logic                data_sram_en,
  input  logic [DATA_W/8-1:0] data_sram_wen,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic [DATA_W-1:0]   data_sram_rdata,
  // core stall
  output logic                stall_by_sram,
  // memory bus
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  typedef enum logic {
    SRC_INST,
    SRC_DATA
  } src_t;

  state_t state, state_nxt;

  // Latched fields of the transaction currently owned by the bus.
  src_t              src_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] wdata_q;

  logic              inst_done, data_done;
  logic [DATA_W-1:0] inst_rdata_q, data_rdata_q;

  logic inst_pend, data_pend;
  logic issue, complete;

  // A source is pending when the core enables it and this cycle's access
  // for it has not finished yet.
  assign inst_pend     = inst_sram_en & ~inst_done;
  assign data_pend     = data_sram_en & ~data_done;
  assign stall_by_sram = inst_pend | data_pend;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is only ever updated with non-blocking
    // assignments so every flop samples the pre-edge values of its peers.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_nxt = state;
    issue     = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (data_pend || inst_pend) begin
          issue     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_addr_ok) state_nxt = WAIT;
      end
      WAIT: begin
        // A data_ok outside WAIT is a slave protocol error and is ignored.
        if (mem_data_ok) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture: data wins over instruction when both are pending.
  // ---------------------------------------------------------------------------
  // NOTE: the request fields carry no reset; they are only observed while
  // mem_req is high, and that is always preceded by a capture.
  always_ff @(posedge clk) begin
    if (issue) begin
      if (data_pend) begin
        src_q   <= SRC_DATA;
        addr_q  <= data_sram_addr;
        wr_q    <= |data_sram_wen;
        wstrb_q <= data_sram_wen;
        wdata_q <= data_sram_wdata;
      end else begin
        src_q   <= SRC_INST;
        addr_q  <= inst_sram_addr;
        wr_q    <= 1'b0;
        wstrb_q <= '0;
        wdata_q <= '0;
      end
    end
  end

  assign mem_req   = (state == REQ);
  assign mem_wr    = wr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // ---------------------------------------------------------------------------
  // Completion bookkeeping
  // ---------------------------------------------------------------------------
  // Done flags live for one core cycle: cleared as soon as nothing is stalled,
  // i.e. the core has consumed the results and may present new requests.
  // A source that withdrew its request is not marked done, so a later
  // re-request is serviced again.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_done <= 1'b0;
      data_done <= 1'b0;
    end else if (!stall_by_sram) begin
      inst_done <= 1'b0;
      data_done <= 1'b0;
    end else if (complete) begin
      if (src_q == SRC_INST && inst_sram_en) inst_done <= 1'b1;
      if (src_q == SRC_DATA && data_sram_en) data_done <= 1'b1;
    end
  end

  // Read data is buffered even for a withdrawn request; writes leave the
  // data buffer untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else if (complete && !wr_q) begin
      if (src_q == SRC_INST) inst_rdata_q <= mem_rdata;
      else                   data_rdata_q <= mem_rdata;
    end
  end

  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_bus_arbiter
//
// Self-checking bench for sram_bus_arbiter. A behavioural bus slave with
// programmable addr_ok / data_ok delays answers the DUT and pops the expected
// request from a scoreboard queue each time it accepts one. Core-side stimulus
// is a table of vectors plus hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_sram_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BUDGET = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_sram_en;
  logic [AW-1:0] inst_sram_addr;
  logic [DW-1:0] inst_sram_rdata;
  logic          data_sram_en;
  logic [3:0]    data_sram_wen;
  logic [AW-1:0] data_sram_addr;
  logic [DW-1:0] data_sram_wdata;
  logic [DW-1:0] data_sram_rdata;
  logic          stall_by_sram;
  logic          mem_req;
  logic          mem_wr;
  logic [3:0]    mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_addr_ok;
  logic          mem_data_ok;
  logic [DW-1:0] mem_rdata;

  sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stall_by_sram   (stall_by_sram),
    .mem_req         (mem_req),
    .mem_wr          (mem_wr),
    .mem_wstrb       (mem_wstrb),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_addr_ok     (mem_addr_ok),
    .mem_data_ok     (mem_data_ok),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Shared bench state
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr;
    logic [3:0]    wstrb;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    logic          i_en;
    logic [AW-1:0] i_addr;
    logic          d_en;
    logic [3:0]    d_wen;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    int            a_dly;
    int            d_dly;
    int            exp_low;
    int            exp_txns;
  } vec_t;

  txn_t  sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    addr_dly = 0;
  int    data_dly = 1;
  int    n_acc = 0;
  int    n_dok = 0;
  int    spur_req = 0;
  int    spur_done = 0;
  logic [DW-1:0] exp_ird = '0;
  logic [DW-1:0] exp_drd = '0;

  // Memory contents seen by the slave: a fixed function of the address.
  function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Advance until the stall drops; c counts cycles elapsed.
  task automatic wait_low(input string tag, output int c);
    c = 0;
    while (stall_by_sram && c < BUDGET) begin
      step();
      c++;
    end
    check({tag, " stall released within budget"}, 64'(c < BUDGET), 64'(1));
  endtask

  // ---------------------------------------------------------------------------
  // Bus slave model + scoreboard consumer
  // ---------------------------------------------------------------------------
  initial begin
    int            req_age;
    int            d_age;
    logic          in_wait;
    logic          had_req;
    logic [AW-1:0] cur_addr;
    txn_t          first;
    txn_t          e;
    req_age = 0; d_age = 0; in_wait = 1'b0; had_req = 1'b0; cur_addr = '0; first = '0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '1;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        req_age = 0; d_age = 0; in_wait = 1'b0; had_req = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '1;
        continue;
      end
      // Account for the handshakes of the cycle that just ended.
      if (mem_data_ok && in_wait) begin
        in_wait = 1'b0;
        n_dok++;
      end else if (in_wait) begin
        d_age++;
      end
      if (mem_addr_ok) begin
        in_wait = 1'b1;
        d_age   = 0;
        req_age = 0;
      end else if (had_req) begin
        req_age++;
      end
      // Drive this cycle's responses.
      had_req     = mem_req;
      mem_addr_ok = mem_req && (req_age >= addr_dly);
      if (mem_req) begin
        if (req_age == 0) begin
          first = '{mem_addr, mem_wr, mem_wstrb, mem_wdata};
        end else begin
          check("held mem_addr", 64'(mem_addr), 64'(first.addr));
          check("held mem_wr", 64'(mem_wr), 64'(first.wr));
          check("held mem_wstrb", 64'(mem_wstrb), 64'(first.wstrb));
          check("held mem_wdata", 64'(mem_wdata), 64'(first.wdata));
        end
        if (mem_addr_ok) begin
          n_acc++;
          cur_addr = mem_addr;
          check("request has scoreboard entry", 64'(sb_q.size() != 0), 64'(1));
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("bus addr", 64'(mem_addr), 64'(e.addr));
            check("bus wr", 64'(mem_wr), 64'(e.wr));
            check("bus wstrb", 64'(mem_wstrb), 64'(e.wstrb));
            if (e.wr) check("bus wdata", 64'(mem_wdata), 64'(e.wdata));
          end
        end
      end
      mem_data_ok = in_wait && (d_age + 1 == data_dly);
      if (mem_data_ok) begin
        mem_rdata = rd_word(cur_addr);
      end else if (spur_req != spur_done && !in_wait && !mem_req) begin
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h1111_1111;
        spur_done++;
      end else begin
        mem_rdata = '1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Table-driven vector runner
  // ---------------------------------------------------------------------------
  task automatic run_vec(input vec_t v, input string tag);
    int c;
    int acc0;
    addr_dly = v.a_dly;
    data_dly = v.d_dly;
    acc0     = n_acc;
    if (v.d_en) begin
      sb_q.push_back('{v.d_addr, |v.d_wen, v.d_wen, v.d_wdata});
      if (v.d_wen == 4'b0000) exp_drd = rd_word(v.d_addr);
    end
    if (v.i_en) begin
      sb_q.push_back('{v.i_addr, 1'b0, 4'b0000, 32'h0});
      exp_ird = rd_word(v.i_addr);
    end
    inst_sram_en    = v.i_en;
    inst_sram_addr  = v.i_addr;
    data_sram_en    = v.d_en;
    data_sram_wen   = v.d_wen;
    data_sram_addr  = v.d_addr;
    data_sram_wdata = v.d_wdata;
    #1;
    check({tag, " stall in cycle 0"}, 64'(stall_by_sram), 64'(1));
    wait_low(tag, c);
    check({tag, " stall-low cycle"}, 64'(c), 64'(v.exp_low));
    check({tag, " inst_sram_rdata"}, 64'(inst_sram_rdata), 64'(exp_ird));
    check({tag, " data_sram_rdata"}, 64'(data_sram_rdata), 64'(exp_drd));
    check({tag, " bus transactions"}, 64'(n_acc - acc0), 64'(v.exp_txns));
    check({tag, " scoreboard drained"}, 64'(sb_q.size()), 64'(0));
    inst_sram_en = 1'b0;
    data_sram_en = 1'b0;
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  vec_t vecs[5];

  initial begin
    int c;
    int acc0;
    int dok0;
    int s0;

    vecs[0] = '{1'b1, 32'hBFC0_0004, 1'b1, 4'b0000, 32'h8000_1000, 32'h0,         0, 1, 6,  2};
    vecs[1] = '{1'b0, 32'h0,         1'b1, 4'b0011, 32'h8000_2000, 32'hDEAD_BEEF, 0, 1, 3,  1};
    vecs[2] = '{1'b1, 32'h0040_0000, 1'b0, 4'b0000, 32'h0,         32'h0,         4, 3, 9,  1};
    vecs[3] = '{1'b1, 32'h0000_1000, 1'b1, 4'b0000, 32'h8000_3000, 32'h0,         1, 2, 10, 2};
    vecs[4] = '{1'b1, 32'h0000_2000, 1'b1, 4'b1111, 32'h0000_1100, 32'h0123_4567, 0, 1, 6,  2};

    rst             = 1'b1;
    inst_sram_en    = 1'b0;
    inst_sram_addr  = '0;
    data_sram_en    = 1'b0;
    data_sram_wen   = '0;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    repeat (3) step();

    // Reset state
    check("reset mem_req", 64'(mem_req), 64'(0));
    check("reset inst_sram_rdata", 64'(inst_sram_rdata), 64'(0));
    check("reset data_sram_rdata", 64'(data_sram_rdata), 64'(0));
    check("reset stall idle", 64'(stall_by_sram), 64'(0));
    inst_sram_en = 1'b1;
    #1;
    check("reset stall follows en", 64'(stall_by_sram), 64'(1));
    inst_sram_en = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Minimum-latency fetch, cycle by cycle
    addr_dly = 0;
    data_dly = 1;
    acc0     = n_acc;
    sb_q.push_back('{32'hBFC0_0000, 1'b0, 4'b0000, 32'h0});
    exp_ird        = rd_word(32'hBFC0_0000);
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'hBFC0_0000;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) #1;
      else        step();
      check($sformatf("fetch mem_req cycle %0d", k), 64'(mem_req), 64'(k == 1));
      check($sformatf("fetch stall cycle %0d", k), 64'(stall_by_sram), 64'(k < 3));
    end
    check("fetch inst_sram_rdata", 64'(inst_sram_rdata), 64'(exp_ird));
    check("fetch bus transactions", 64'(n_acc - acc0), 64'(1));
    inst_sram_en = 1'b0;
    step();

    // Table vectors
    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Spurious data_ok while idle must not disturb the buffers
    s0 = spur_done;
    spur_req++;
    c = 0;
    while (spur_done == s0 && c < 20) begin
      step();
      c++;
    end
    check("spurious data_ok injected", 64'(spur_done - s0), 64'(1));
    step();
    step();
    check("spurious inst_sram_rdata", 64'(inst_sram_rdata), 64'(exp_ird));
    check("spurious data_sram_rdata", 64'(data_sram_rdata), 64'(exp_drd));
    check("spurious mem_req", 64'(mem_req), 64'(0));

    // Data read withdrawn while in REQ: still completes and is buffered
    addr_dly = 2;
    data_dly = 2;
    dok0     = n_dok;
    sb_q.push_back('{32'h8000_4000, 1'b0, 4'b0000, 32'h0});
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'b0000;
    data_sram_addr = 32'h8000_4000;
    step();
    check("withdraw mem_req", 64'(mem_req), 64'(1));
    data_sram_en = 1'b0;
    #1;
    check("withdraw stall", 64'(stall_by_sram), 64'(0));
    c = 0;
    while (n_dok == dok0 && c < 20) begin
      step();
      c++;
    end
    check("withdraw completed on bus", 64'(n_dok - dok0), 64'(1));
    exp_drd = rd_word(32'h8000_4000);
    check("withdraw data buffered", 64'(data_sram_rdata), 64'(exp_drd));
    step();
    data_sram_en   = 1'b1;
    data_sram_addr = 32'h8000_5000;
    sb_q.push_back('{32'h8000_5000, 1'b0, 4'b0000, 32'h0});
    exp_drd = rd_word(32'h8000_5000);
    #1;
    check("re-request stalls", 64'(stall_by_sram), 64'(1));
    wait_low("re-request", c);
    check("re-request data_sram_rdata", 64'(data_sram_rdata), 64'(exp_drd));
    check("re-request scoreboard drained", 64'(sb_q.size()), 64'(0));
    data_sram_en = 1'b0;
    step();

    // Reset while the fetch is in WAIT
    addr_dly = 0;
    data_dly = 3;
    sb_q.push_back('{32'h0050_0000, 1'b0, 4'b0000, 32'h0});
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'h0050_0000;
    step();
    step();
    check("pre-reset in WAIT", 64'(mem_req), 64'(0));
    rst = 1'b1;
    step();
    check("wait-reset mem_req", 64'(mem_req), 64'(0));
    check("wait-reset inst_sram_rdata", 64'(inst_sram_rdata), 64'(0));
    check("wait-reset data_sram_rdata", 64'(data_sram_rdata), 64'(0));
    check("wait-reset stall with en", 64'(stall_by_sram), 64'(1));
    inst_sram_en = 1'b0;
    #1;
    check("wait-reset stall without en", 64'(stall_by_sram), 64'(0));
    inst_sram_en = 1'b1;
    exp_drd = '0;
    exp_ird = rd_word(32'h0050_0000);
    sb_q.push_back('{32'h0050_0000, 1'b0, 4'b0000, 32'h0});
    rst = 1'b0;
    #1;
    wait_low("post-reset fetch", c);
    check("post-reset inst_sram_rdata", 64'(inst_sram_rdata), 64'(exp_ird));
    check("post-reset data_sram_rdata", 64'(data_sram_rdata), 64'(exp_drd));
    check("post-reset scoreboard drained", 64'(sb_q.size()), 64'(0));
    inst_sram_en = 1'b0;
    step();

    // Back-to-back fetches, en held high across handoffs
    addr_dly = 0;
    data_dly = 1;
    acc0     = n_acc;
    inst_sram_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inst_sram_addr = 32'(i * 4);
      sb_q.push_back('{32'(i * 4), 1'b0, 4'b0000, 32'h0});
      exp_ird = rd_word(32'(i * 4));
      if (i > 0) step();
      else       #1;
      check($sformatf("b2b fetch %0d stalls", i), 64'(stall_by_sram), 64'(1));
      wait_low($sformatf("b2b fetch %0d", i), c);
      check($sformatf("b2b fetch %0d latency", i), 64'(c), 64'(3));
      check($sformatf("b2b fetch %0d rdata", i), 64'(inst_sram_rdata), 64'(exp_ird));
    end
    inst_sram_en = 1'b0;
    repeat (4) step();
    check("b2b bus transactions", 64'(n_acc - acc0), 64'(3));
    check("b2b scoreboard drained", 64'(sb_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
